// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the sequenced reset-release block.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        HOLD,
        WAIT_ACK,
        DONE,
        ERROR
    } seq_state_t;

    // Stage index width; a single-stage build still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The shared down-counter only ever holds (limit - 1), so $clog2 of the largest limit suffices.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/rst_seq_cdc_sync2.sv
// Purpose: two-flop synchronizer for a slow asynchronous level (PLL lock).
// Latency: 2 sys_clk edges from input change to sync_out.
// Backpressure: none; free-running level path.
module cdc_sync2 (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic async_in,
    output logic sync_out
);

    (* ASYNC_REG = "TRUE" *) logic [1:0] sync_ff;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[0], async_in};
        end
    end

    assign sync_out = sync_ff[1];

endmodule

// File: rtl/rst_seq.sv
// Purpose: releases per-stage active-low resets in order once both PLLs hold lock.
// Latency: first release 2+LOCK_FILT+DLY_CYCLES edges after reset; 1+DLY_CYCLES per further stage.
// Backpressure: waits on stage_ack[i] up to ACK_TIMEOUT cycles, then latches an error.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int N_STAGES    = 4,
    parameter int LOCK_FILT   = 8,
    parameter int DLY_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                               sys_clk,
    input  logic                               sys_rst,
    input  logic                               adc_pll_locked,
    input  logic                               dac_pll_locked,
    input  logic                               soft_rst_req,
    input  logic [N_STAGES-1:0]                stage_ack,
    output logic [N_STAGES-1:0]                stage_rst_n,
    output logic                               seq_done,
    output logic                               seq_err,
    output logic [idx_width(N_STAGES)-1:0]     err_stage
);

    localparam int IDX_W = idx_width(N_STAGES);
    localparam int CNT_W = cnt_width(LOCK_FILT, DLY_CYCLES, ACK_TIMEOUT);

    localparam logic [CNT_W-1:0] FILT_LOAD = CNT_W'(LOCK_FILT - 1);
    localparam logic [CNT_W-1:0] DLY_LOAD  = CNT_W'(DLY_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LOAD  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_STAGES - 1);

    logic adc_lock_s;
    logic dac_lock_s;
    logic lock_s;

    cdc_sync2 u_adc_sync (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .async_in (adc_pll_locked),
        .sync_out (adc_lock_s)
    );

    cdc_sync2 u_dac_sync (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .async_in (dac_pll_locked),
        .sync_out (dac_lock_s)
    );

    assign lock_s = adc_lock_s & dac_lock_s;

    seq_state_t           state_q, state_nxt;
    logic [CNT_W-1:0]     cnt_q, cnt_nxt;
    logic [IDX_W-1:0]     idx_q, idx_nxt;
    logic [N_STAGES-1:0]  rst_n_nxt;
    logic                 done_nxt;
    logic                 err_nxt;
    logic [IDX_W-1:0]     err_stage_nxt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            idx_q       <= '0;
            stage_rst_n <= '0;
            seq_done    <= 1'b0;
            seq_err     <= 1'b0;
            err_stage   <= '0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            idx_q       <= idx_nxt;
            stage_rst_n <= rst_n_nxt;
            seq_done    <= done_nxt;
            seq_err     <= err_nxt;
            err_stage   <= err_stage_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        cnt_nxt       = cnt_q;
        idx_nxt       = idx_q;
        rst_n_nxt     = stage_rst_n;
        done_nxt      = seq_done;
        err_nxt       = seq_err;
        err_stage_nxt = err_stage;

        // Lock loss outranks a software request, so a coincident pair keeps the error record.
        if (!lock_s && (state_q != WAIT_LOCK)) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = FILT_LOAD;
            idx_nxt   = '0;
            rst_n_nxt = '0;
            done_nxt  = 1'b0;
        end else if (soft_rst_req) begin
            state_nxt     = WAIT_LOCK;
            cnt_nxt       = FILT_LOAD;
            idx_nxt       = '0;
            rst_n_nxt     = '0;
            done_nxt      = 1'b0;
            err_nxt       = 1'b0;
            err_stage_nxt = '0;
        end else begin
            unique case (state_q)
                WAIT_LOCK: begin
                    if (!lock_s) begin
                        cnt_nxt = FILT_LOAD;
                    end else if (cnt_q == '0) begin
                        state_nxt = HOLD;
                        cnt_nxt   = DLY_LOAD;
                        idx_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_q - 1'b1;
                    end
                end

                HOLD: begin
                    if (cnt_q == '0) begin
                        rst_n_nxt[idx_q] = 1'b1;
                        state_nxt        = WAIT_ACK;
                        cnt_nxt          = ACK_LOAD;
                    end else begin
                        cnt_nxt = cnt_q - 1'b1;
                    end
                end

                // Ack is tested before the timeout so a last-cycle ack still counts.
                WAIT_ACK: begin
                    if (stage_ack[idx_q]) begin
                        if (idx_q == LAST_IDX) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = HOLD;
                            idx_nxt   = idx_q + 1'b1;
                            cnt_nxt   = DLY_LOAD;
                        end
                    end else if (cnt_q == '0) begin
                        state_nxt     = ERROR;
                        rst_n_nxt     = '0;
                        err_nxt       = 1'b1;
                        err_stage_nxt = idx_q;
                    end else begin
                        cnt_nxt = cnt_q - 1'b1;
                    end
                end

                DONE: begin
                    done_nxt = 1'b1;
                end

                ERROR: begin
                    rst_n_nxt = '0;
                end

                default: begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = FILT_LOAD;
                    rst_n_nxt = '0;
                    done_nxt  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq at default parameters; edge numbers are counted from the sys_rst drop.
module tb_rst_seq;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       adc_pll_locked;
    logic       dac_pll_locked;
    logic       soft_rst_req;
    logic [3:0] stage_ack;
    logic [3:0] stage_rst_n;
    logic       seq_done;
    logic       seq_err;
    logic [1:0] err_stage;

    int vectors     = 0;
    int miscompares = 0;
    int t           = 0;

    rst_seq dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .adc_pll_locked (adc_pll_locked),
        .dac_pll_locked (dac_pll_locked),
        .soft_rst_req   (soft_rst_req),
        .stage_ack      (stage_ack),
        .stage_rst_n    (stage_rst_n),
        .seq_done       (seq_done),
        .seq_err        (seq_err),
        .err_stage      (err_stage)
    );

    always #5 sys_clk = ~sys_clk;

    // Advance n edges and settle 1 time unit past the last one.
    task automatic wait_edges(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
            t++;
        end
    endtask

    // Pulse sys_rst; the edge just before release becomes edge 0.
    task automatic start_seq(input logic [3:0] acks);
        stage_ack      = acks;
        adc_pll_locked = 1'b1;
        dac_pll_locked = 1'b1;
        soft_rst_req   = 1'b0;
        sys_rst        = 1'b1;
        wait_edges(2);
        sys_rst = 1'b0;
        t       = 0;
    endtask

    // Release pattern with immediate acks: stage k rises at r0 + 17*k.
    function automatic logic [3:0] exp_rel(input int e, input int r0);
        logic [3:0] r;
        r = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (e >= r0 + 17 * k) r[k] = 1'b1;
        end
        return r;
    endfunction

    task automatic test_reset();
        wait_edges(3);
        vectors++;
        if (stage_rst_n !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_rst_n got=%b exp=%b", stage_rst_n, 4'b0000);
        end
        vectors++;
        if (seq_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done got=%b exp=0", seq_done);
        end
        vectors++;
        if (seq_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err got=%b exp=0", seq_err);
        end
        vectors++;
        if (err_stage !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_err_stage got=%0d exp=0", err_stage);
        end
    endtask

    task automatic test_startup();
        logic [3:0] exp_r;
        start_seq(4'b1111);
        for (int e = 1; e <= 78; e++) begin
            wait_edges(1);
            exp_r = exp_rel(t, 26);
            vectors++;
            if (stage_rst_n !== exp_r) begin
                miscompares++;
                $display("FAIL startup_rst_n edge=%0d got=%b exp=%b", t, stage_rst_n, exp_r);
            end
            vectors++;
            if (seq_done !== (t >= 78)) begin
                miscompares++;
                $display("FAIL startup_done edge=%0d got=%b exp=%b", t, seq_done, (t >= 78));
            end
        end
        // DONE ignores acks dropping.
        stage_ack = 4'b0000;
        wait_edges(4);
        vectors++;
        if (stage_rst_n !== 4'b1111 || seq_done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_ack_drop got=%b/%b exp=1111/1", stage_rst_n, seq_done);
        end
        stage_ack = 4'b1111;
    endtask

    task automatic test_lock_glitch();
        logic [3:0] exp_r;
        start_seq(4'b1111);
        // Raw ADC lock is low at edges 4..6, so the filter last clears at edge 8.
        for (int e = 1; e <= 33; e++) begin
            wait_edges(1);
            if (t == 3) adc_pll_locked = 1'b0;
            if (t == 6) adc_pll_locked = 1'b1;
            exp_r = (t >= 32) ? 4'b0001 : 4'b0000;
            vectors++;
            if (stage_rst_n !== exp_r) begin
                miscompares++;
                $display("FAIL glitch_rst_n edge=%0d got=%b exp=%b", t, stage_rst_n, exp_r);
            end
        end
    endtask

    task automatic test_ack_timeout();
        start_seq(4'b1011);
        wait_edges(59);
        vectors++;
        if (stage_rst_n !== 4'b0011) begin
            miscompares++;
            $display("FAIL timeout_pre2 got=%b exp=0011", stage_rst_n);
        end
        wait_edges(1);
        vectors++;
        if (stage_rst_n !== 4'b0111) begin
            miscompares++;
            $display("FAIL timeout_rel2 got=%b exp=0111", stage_rst_n);
        end
        wait_edges(1023);
        vectors++;
        if (stage_rst_n !== 4'b0111 || seq_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early got=%b/%b exp=0111/0", stage_rst_n, seq_err);
        end
        wait_edges(1);
        vectors++;
        if (stage_rst_n !== 4'b0000 || seq_err !== 1'b1 || err_stage !== 2'd2) begin
            miscompares++;
            $display("FAIL timeout_err got=%b/%b/%0d exp=0000/1/2", stage_rst_n, seq_err, err_stage);
        end
    endtask

    task automatic test_lock_loss_error();
        stage_ack = 4'b1111;
        wait_edges(2);
        dac_pll_locked = 1'b0;
        wait_edges(3);
        vectors++;
        if (stage_rst_n !== 4'b0000 || seq_err !== 1'b1 || err_stage !== 2'd2) begin
            miscompares++;
            $display("FAIL errloss_keep got=%b/%b/%0d exp=0000/1/2", stage_rst_n, seq_err, err_stage);
        end
        wait_edges(1);
        dac_pll_locked = 1'b1;
        wait_edges(25);
        vectors++;
        if (stage_rst_n !== 4'b0000) begin
            miscompares++;
            $display("FAIL errloss_pre got=%b exp=0000", stage_rst_n);
        end
        wait_edges(1);
        vectors++;
        if (stage_rst_n !== 4'b0001) begin
            miscompares++;
            $display("FAIL errloss_rel0 got=%b exp=0001", stage_rst_n);
        end
        wait_edges(51);
        vectors++;
        if (stage_rst_n !== 4'b1111 || seq_done !== 1'b0) begin
            miscompares++;
            $display("FAIL errloss_rel3 got=%b/%b exp=1111/0", stage_rst_n, seq_done);
        end
        wait_edges(1);
        vectors++;
        if (seq_done !== 1'b1 || seq_err !== 1'b1 || err_stage !== 2'd2) begin
            miscompares++;
            $display("FAIL errloss_done got=%b/%b/%0d exp=1/1/2", seq_done, seq_err, err_stage);
        end
    endtask

    task automatic test_lock_loss_done();
        wait_edges(2);
        dac_pll_locked = 1'b0;
        wait_edges(2);
        vectors++;
        if (stage_rst_n !== 4'b1111 || seq_done !== 1'b1) begin
            miscompares++;
            $display("FAIL loss_early got=%b/%b exp=1111/1", stage_rst_n, seq_done);
        end
        wait_edges(1);
        vectors++;
        if (stage_rst_n !== 4'b0000 || seq_done !== 1'b0 || seq_err !== 1'b1) begin
            miscompares++;
            $display("FAIL loss_drop got=%b/%b/%b exp=0000/0/1", stage_rst_n, seq_done, seq_err);
        end
        wait_edges(2);
        dac_pll_locked = 1'b1;
        wait_edges(25);
        vectors++;
        if (stage_rst_n !== 4'b0000) begin
            miscompares++;
            $display("FAIL loss_pre got=%b exp=0000", stage_rst_n);
        end
        wait_edges(1);
        vectors++;
        if (stage_rst_n !== 4'b0001) begin
            miscompares++;
            $display("FAIL loss_rel0 got=%b exp=0001", stage_rst_n);
        end
        wait_edges(51);
        vectors++;
        if (stage_rst_n !== 4'b1111) begin
            miscompares++;
            $display("FAIL loss_rel3 got=%b exp=1111", stage_rst_n);
        end
        wait_edges(1);
        vectors++;
        if (seq_done !== 1'b1) begin
            miscompares++;
            $display("FAIL loss_done got=%b exp=1", seq_done);
        end
    endtask

    task automatic test_soft_restart();
        wait_edges(2);
        soft_rst_req = 1'b1;
        wait_edges(1);
        soft_rst_req = 1'b0;
        vectors++;
        if (stage_rst_n !== 4'b0000 || seq_done !== 1'b0 || seq_err !== 1'b0 || err_stage !== 2'd0) begin
            miscompares++;
            $display("FAIL soft_clear got=%b/%b/%b/%0d exp=0000/0/0/0", stage_rst_n, seq_done, seq_err, err_stage);
        end
        wait_edges(23);
        vectors++;
        if (stage_rst_n !== 4'b0000) begin
            miscompares++;
            $display("FAIL soft_pre got=%b exp=0000", stage_rst_n);
        end
        wait_edges(1);
        vectors++;
        if (stage_rst_n !== 4'b0001) begin
            miscompares++;
            $display("FAIL soft_rel0 got=%b exp=0001", stage_rst_n);
        end
    endtask

    task automatic test_back_to_back();
        start_seq(4'b0111);
        wait_edges(77);
        vectors++;
        if (stage_rst_n !== 4'b1111 || seq_done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_rel3 got=%b/%b exp=1111/0", stage_rst_n, seq_done);
        end
        wait_edges(3);
        stage_ack    = 4'b1111;
        soft_rst_req = 1'b1;
        wait_edges(1);
        soft_rst_req = 1'b0;
        vectors++;
        if (stage_rst_n !== 4'b0000 || seq_done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_restart got=%b/%b exp=0000/0", stage_rst_n, seq_done);
        end
        for (int e = 0; e < 23; e++) begin
            wait_edges(1);
            vectors++;
            if (seq_done !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_no_done edge=%0d got=%b exp=0", t, seq_done);
            end
        end
        vectors++;
        if (stage_rst_n !== 4'b0000) begin
            miscompares++;
            $display("FAIL b2b_pre got=%b exp=0000", stage_rst_n);
        end
        wait_edges(1);
        vectors++;
        if (stage_rst_n !== 4'b0001) begin
            miscompares++;
            $display("FAIL b2b_rel0 got=%b exp=0001", stage_rst_n);
        end
    endtask

    task automatic test_sys_rst_hold();
        start_seq(4'b1111);
        wait_edges(50);
        vectors++;
        if (stage_rst_n !== 4'b0011) begin
            miscompares++;
            $display("FAIL sysrst_before got=%b exp=0011", stage_rst_n);
        end
        sys_rst = 1'b1;
        wait_edges(1);
        sys_rst = 1'b0;
        vectors++;
        if (stage_rst_n !== 4'b0000 || seq_done !== 1'b0 || seq_err !== 1'b0 || err_stage !== 2'd0) begin
            miscompares++;
            $display("FAIL sysrst_clear got=%b/%b/%b/%0d exp=0000/0/0/0", stage_rst_n, seq_done, seq_err, err_stage);
        end
        // Edge 51 now plays the role of edge 0.
        wait_edges(25);
        vectors++;
        if (stage_rst_n !== 4'b0000) begin
            miscompares++;
            $display("FAIL sysrst_pre got=%b exp=0000", stage_rst_n);
        end
        wait_edges(1);
        vectors++;
        if (stage_rst_n !== 4'b0001) begin
            miscompares++;
            $display("FAIL sysrst_rel0 got=%b exp=0001", stage_rst_n);
        end
    endtask

    initial begin
        sys_rst        = 1'b1;
        adc_pll_locked = 1'b1;
        dac_pll_locked = 1'b1;
        soft_rst_req   = 1'b0;
        stage_ack      = 4'b1111;

        test_reset();
        test_startup();
        test_lock_glitch();
        test_ack_timeout();
        test_lock_loss_error();
        test_lock_loss_done();
        test_soft_restart();
        test_back_to_back();
        test_sys_rst_hold();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
# rst_seq

Sequenced reset-release block consuming the system reset and the ADC/DAC PLL lock indications. Releases per-subsystem active-low resets one stage at a time (e.g. ADC path, DSP core, DAC path, CPU): a fixed hold delay before each release, then the stage's ready acknowledge before moving on. Any PLL lock loss or software reset request re-asserts all stage resets and restarts the sequence. It sits directly behind clock/reset generation in the `sys_clk` domain.

## Interface
Parameters:
- `N_STAGES`, 4: number of sequenced reset outputs (1..8).
- `LOCK_FILT`, 8: consecutive cycles both synchronized locks must be high before sequencing starts (≥1).
- `DLY_CYCLES`, 16: hold cycles before each stage release (≥1).
- `ACK_TIMEOUT`, 1024: maximum cycles in WAIT_ACK before error (≥2).

Ports:
- `sys_clk`  in  1  system clock; the only clock.
- `sys_rst`  in  1  reset, synchronous, active-high.
- `adc_pll_locked`  in  1  ADC PLL lock; asynchronous, synchronized internally.
- `dac_pll_locked`  in  1  DAC PLL lock; asynchronous, synchronized internally.
- `soft_rst_req`  in  1  single-cycle software restart request, `sys_clk` domain.
- `stage_ack`  in  N_STAGES  per-stage ready, `sys_clk` domain (stages synchronize externally).
- `stage_rst_n`  out  N_STAGES  per-stage reset, active-low, registered.
- `seq_done`  out  1  all stages released and acknowledged.
- `seq_err`  out  1  sticky acknowledge-timeout flag.
- `err_stage`  out  $clog2(N_STAGES) (min 1)  index of the stage that timed out.

## Operation
- Reset values: `stage_rst_n`=0, `seq_done`=0, `seq_err`=0, `err_stage`=0, state WAIT_LOCK, all counters 0, synchronizer flops 0.
- `lock_s` = AND of both 2-flop-synchronized locks.
- States:
  - WAIT_LOCK: filter counter increments while `lock_s`=1 and clears when `lock_s`=0. At LOCK_FILT it moves to HOLD with stage index i=0.
  - HOLD: counts DLY_CYCLES cycles. On the final one it sets `stage_rst_n[i]`=1 and moves to WAIT_ACK.
  - WAIT_ACK: samples only `stage_ack[i]`.
    - Ack=1 with i<N_STAGES-1: i++, go to HOLD.
    - Ack=1 with i=N_STAGES-1: go to DONE.
    - ACK_TIMEOUT cycles without ack: go to ERROR.
    - Ack in the same cycle as timeout expiry: ack wins.
    - Ack already high on WAIT_ACK entry: accepted in the first WAIT_ACK cycle.
  - DONE: `seq_done`=1. Acks are ignored; a stage dropping its ack has no effect.
  - ERROR: all `stage_rst_n`=0, `seq_err`=1, `err_stage`=i. Stays in ERROR until a restart event.
- Restart events, in priority order (`sys_rst` highest, then lock loss, then `soft_rst_req`, then normal transitions):
  - `sys_rst`: returns to reset values.
  - `lock_s`=0 in any state other than WAIT_LOCK: all `stage_rst_n`=0 and `seq_done`=0 on the next edge; go to WAIT_LOCK. `seq_err`/`err_stage` are kept.
  - `soft_rst_req`=1 in any state: same as lock loss, and also clears `seq_err`/`err_stage`.
- Released stages remain released while later stages sequence. Release is monotonic: `stage_rst_n[k]` never rises before `stage_rst_n[k-1]`.

## Timing
- Lock synchronizer latency: 2 cycles.
- Startup: `sys_rst` drops at edge 0 with both locks high, acks tied high. Then `stage_rst_n[0]` rises at edge 2+LOCK_FILT+DLY_CYCLES (26 with defaults).
- Each subsequent stage (ack immediate) rises 1+DLY_CYCLES edges after the previous one (17 with defaults).
- `seq_done` rises 1 edge after the last stage's ack is sampled.
- Raw lock drop to all resets asserted: 3 edges.
- `soft_rst_req` to all resets asserted: 1 edge.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- `rst_seq_pkg`: state enum (WAIT_LOCK, HOLD, WAIT_ACK, DONE, ERROR) and counter-width helper functions built on $clog2.
- Sub-module `cdc_sync2`: 2-flop synchronizer with an ASYNC_REG attribute, instantiated once per lock input.
- One shared down-counter serves LOCK_FILT, DLY_CYCLES and ACK_TIMEOUT, sized to the largest of the three.

## Test plan
- Nominal startup: defaults, locks high, acks tied high → `stage_rst_n` goes 0001/0011/0111/1111 at edges 26/43/60/77; `seq_done`=1 at edge 78.
- Lock glitch: `adc_pll_locked` low for 3 cycles during WAIT_LOCK → filter restarts; stage 0 release delayed by exactly glitch length + 3 cycles; no output toggles early.
- Ack timeout: `stage_ack[2]` held 0 → 1024 cycles after `stage_rst_n[2]` rises, all `stage_rst_n`=0, `seq_err`=1, `err_stage`=2. `soft_rst_req` then clears the error and the sequence reruns.
- Lock loss in DONE: drop `dac_pll_locked` → `stage_rst_n`=0 and `seq_done`=0 within 3 edges, `seq_err` unchanged. Restore lock → full sequence repeats.
- Simultaneous events: `soft_rst_req` in the same cycle as the final ack → restart wins, `seq_done` never asserts. `sys_rst` mid-HOLD → all outputs return to reset values on the next edge.
